// File: rtl/reg_apb_pkg.sv
// Shared types and constants for the register-bus to APB4 bridge.
//   state_e       : bridge FSM states (IDLE, SETUP, ACCESS, DONE)
//   PPROT_DEFAULT : protection attributes driven on every APB access
package reg_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/reg_to_apb.sv
// reg_to_apb: bridges a REG_BUS request (addr/write/wdata/wstrb/valid ->
// ready/rdata/error) onto an APB4 requester port, one access at a time.
// A per-access timeout completes the request with error=1 if the completer
// never raises pready_i.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reg_addr_i/reg_write_i       request address / direction (1 = write)
//   reg_wdata_i/reg_wstrb_i      write data / byte strobes
//   reg_valid_i                  request valid, held until reg_ready_o
//   reg_ready_o                  one-cycle completion pulse
//   reg_rdata_o/reg_error_o      response, non-zero only with reg_ready_o
//   paddr_o/pprot_o/psel_o/penable_o/pwrite_o/pwdata_o/pstrb_o
//                                APB4 requester outputs (all registered)
//   pready_i/prdata_i/pslverr_i  APB4 completer response
module reg_to_apb
  import reg_apb_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  localparam int unsigned StrbWidth    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic                 reg_write_i,
  input  logic [DataWidth-1:0] reg_wdata_i,
  input  logic [StrbWidth-1:0] reg_wstrb_i,
  input  logic                 reg_valid_i,
  output logic                 reg_ready_o,
  output logic [DataWidth-1:0] reg_rdata_o,
  output logic                 reg_error_o,
  output logic [AddrWidth-1:0] paddr_o,
  output logic [2:0]           pprot_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [DataWidth-1:0] pwdata_o,
  output logic [StrbWidth-1:0] pstrb_o,
  input  logic                 pready_i,
  input  logic [DataWidth-1:0] prdata_i,
  input  logic                 pslverr_i
);

  // Counter spans 0..TimeoutCycles; a 1-bit dummy when the timeout is off.
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  // Expiry fires on the ACCESS cycle whose increment would reach TimeoutCycles.
  localparam logic [CntW-1:0] CntLast =
    CntW'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);
  localparam bit TimeoutEn = (TimeoutCycles > 0);

  state_e               state_q,   state_d;
  logic [AddrWidth-1:0] paddr_q,   paddr_d;
  logic                 pwrite_q,  pwrite_d;
  logic [DataWidth-1:0] pwdata_q,  pwdata_d;
  logic [StrbWidth-1:0] pstrb_q,   pstrb_d;
  logic                 psel_q,    psel_d;
  logic                 penable_q, penable_d;
  logic                 ready_q,   ready_d;
  logic [DataWidth-1:0] rdata_q,   rdata_d;
  logic                 error_q,   error_d;
  logic [CntW-1:0]      cnt_q,     cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  // All outputs are registered: each transition computes the values seen
  // in the state being entered.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ready_d   = 1'b0;
    rdata_d   = '0;
    error_d   = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (reg_valid_i) begin
          paddr_d  = reg_addr_i;
          pwrite_d = reg_write_i;
          // Write-only fields are driven to zero on reads.
          pwdata_d = reg_write_i ? reg_wdata_i : '0;
          pstrb_d  = reg_write_i ? reg_wstrb_i : '0;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // pready_i is tested first so a response on the expiry cycle wins.
        if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          rdata_d   = pwrite_q ? '0 : prdata_i;
          error_d   = pslverr_i;
          state_d   = DONE;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          error_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign reg_ready_o = ready_q;
  assign reg_rdata_o = rdata_q;
  assign reg_error_o = error_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = PPROT_DEFAULT;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_reg_to_apb.sv
// Bench for reg_to_apb (TimeoutCycles = 4). Each request is turned into a
// per-cycle timeline of expected outputs from the transfer rules (accept at
// t, SETUP at t+1, n ACCESS cycles, DONE pulse after); a single negedge
// process compares every output against that timeline on every cycle.
module tb_reg_to_apb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int TO = 4;
  localparam int NCYC = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] reg_addr = '0;
  logic          reg_write = 1'b0;
  logic [DW-1:0] reg_wdata = '0;
  logic [SW-1:0] reg_wstrb = '0;
  logic          reg_valid = 1'b0;
  logic          reg_ready;
  logic [DW-1:0] reg_rdata;
  logic          reg_error;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  reg_to_apb #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reg_addr_i (reg_addr),
    .reg_write_i(reg_write),
    .reg_wdata_i(reg_wdata),
    .reg_wstrb_i(reg_wstrb),
    .reg_valid_i(reg_valid),
    .reg_ready_o(reg_ready),
    .reg_rdata_o(reg_rdata),
    .reg_error_o(reg_error),
    .paddr_o    (paddr),
    .pprot_o    (pprot),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .pstrb_o    (pstrb),
    .pready_i   (pready),
    .prdata_i   (prdata),
    .pslverr_i  (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number (cycle c follows posedge c).
  bit          e_psel [NCYC];
  bit          e_pen  [NCYC];
  bit          e_rdy  [NCYC];
  bit          e_err  [NCYC];
  bit [DW-1:0] e_rd   [NCYC];
  bit          e_fld  [NCYC];   // APB fields meaningful this cycle
  bit [AW-1:0] e_addr [NCYC];
  bit          e_pw   [NCYC];
  bit [DW-1:0] e_wd   [NCYC];
  bit [SW-1:0] e_st   [NCYC];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Response monitor used by the literal pins.
  int          rdy_cnt = 0;
  int          last_rdy_cyc = -1;
  logic [DW-1:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      chk("psel",    64'(psel),      64'(e_psel[cyc]));
      chk("penable", 64'(penable),   64'(e_pen[cyc]));
      chk("ready",   64'(reg_ready), 64'(e_rdy[cyc]));
      chk("rdata",   64'(reg_rdata), 64'(e_rd[cyc]));
      chk("error",   64'(reg_error), 64'(e_err[cyc]));
      chk("pprot",   64'(pprot),     64'd0);
      if (e_fld[cyc]) begin
        chk("paddr",  64'(paddr),  64'(e_addr[cyc]));
        chk("pwrite", 64'(pwrite), 64'(e_pw[cyc]));
        chk("pwdata", 64'(pwdata), 64'(e_wd[cyc]));
        chk("pstrb",  64'(pstrb),  64'(e_st[cyc]));
      end
    end
    if (reg_ready === 1'b1) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      last_rdata = reg_rdata;
      last_err = reg_error;
    end
  end

  task automatic zero_fields(input int c);
    e_fld[c]  = 1'b1;
    e_addr[c] = '0;
    e_pw[c]   = 1'b0;
    e_wd[c]   = '0;
    e_st[c]   = '0;
  endtask

  // Issue one request at the current cycle t. The completer answers after
  // `w` wait states; w >= TO means it never answers inside the window.
  task automatic issue(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws, input int w, input logic [DW-1:0] prd,
                       input bit slv, output int t_out);
    int t, n;
    bit tmo;
    t = cyc;
    tmo = (w >= TO);
    n = tmo ? TO : w + 1;
    for (int k = 1; k <= 1 + n; k++) begin
      e_psel[t+k] = 1'b1;
      e_fld[t+k]  = 1'b1;
      e_addr[t+k] = a;
      e_pw[t+k]   = wr;
      e_wd[t+k]   = wr ? wd : '0;
      e_st[t+k]   = wr ? ws : '0;
      if (k >= 2) e_pen[t+k] = 1'b1;
    end
    e_rdy[t+2+n] = 1'b1;
    e_rd[t+2+n]  = tmo ? '0 : (wr ? '0 : prd);
    e_err[t+2+n] = tmo ? 1'b1 : slv;

    reg_addr  = a;
    reg_write = wr;
    reg_wdata = wd;
    reg_wstrb = ws;
    reg_valid = 1'b1;
    for (int c = t; c <= t + 2 + n; c++) begin
      if (c == t + 2 + w) begin
        pready  = 1'b1;
        prdata  = prd;
        pslverr = slv;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    reg_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    t_out = t;
  endtask

  initial begin
    int t;
    int rc;
    // Reset held through posedges 1..3; everything must read zero.
    for (int c = 1; c <= 3; c++) zero_fields(c);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait read: psel t+1, penable t+2, ready t+3.
    issue(32'h0000_0010, 1'b0, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, t);
    chk("rd0_latency", 64'(last_rdy_cyc - t), 64'd3);
    chk("rd0_rdata",   64'(last_rdata),       64'hDEAD_BEEF);

    // Write with 3 wait states, issued back-to-back: ready at t+6.
    issue(32'h0000_0020, 1'b1, 32'h1234_5678, 4'b0011, 3, 32'h5555_AAAA, 1'b0, t);
    chk("wr3_latency", 64'(last_rdy_cyc - t), 64'd6);
    chk("wr3_rdata",   64'(last_rdata),       64'd0);

    // Read completing with pslverr.
    rc = rdy_cnt;
    issue(32'h0000_0030, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1, t);
    chk("slverr_err",    64'(last_err),      64'd1);
    chk("slverr_pulses", 64'(rdy_cnt - rc),  64'd1);

    // Completer never answers: 4 ACCESS cycles then error.
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h0, 1000, 32'h1111_2222, 1'b0, t);
    chk("tmo_latency", 64'(last_rdy_cyc - t), 64'd6);
    chk("tmo_err",     64'(last_err),         64'd1);
    chk("tmo_rdata",   64'(last_rdata),       64'd0);

    // pready on the expiry cycle wins over the timeout.
    issue(32'h0000_0050, 1'b1, 32'hA5A5_5A5A, 4'b1100, TO - 1, 32'h0, 1'b1, t);
    issue(32'h0000_0054, 1'b0, 32'h0, 4'h0, TO - 1, 32'h7777_0007, 1'b0, t);
    chk("edge_rdata", 64'(last_rdata), 64'h7777_0007);
    chk("edge_err",   64'(last_err),   64'd0);

    // Reset during ACCESS: transfer abandoned, no ready pulse.
    rc = rdy_cnt;
    t = cyc;
    e_psel[t+1] = 1'b1;
    e_psel[t+2] = 1'b1;
    e_pen[t+2]  = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      e_fld[t+k]  = 1'b1;
      e_addr[t+k] = 32'h0000_0060;
      e_pw[t+k]   = 1'b1;
      e_wd[t+k]   = 32'hFEED_F00D;
      e_st[t+k]   = 4'hF;
    end
    zero_fields(t + 3);
    reg_addr  = 32'h0000_0060;
    reg_write = 1'b1;
    reg_wdata = 32'hFEED_F00D;
    reg_wstrb = 4'hF;
    reg_valid = 1'b1;
    pready    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_no_pulse", 64'(rdy_cnt - rc), 64'd0);

    // Normal read after the aborted transfer.
    issue(32'h0000_0070, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, t);
    chk("post_rst_latency", 64'(last_rdy_cyc - t), 64'd3);
    chk("post_rst_rdata",   64'(last_rdata),       64'h0BAD_F00D);

    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
